// File: rtl/except_ctrl.sv
// Exception controller for the MEM stage.
// Selects the highest-priority pending cause, reports it to CP0, waits for
// CP0's acknowledge, then issues a one-cycle pipeline flush to the handler
// vector. An eret skips the report and flushes straight to the saved EPC.
//
// Optional feature: define EXC_BADVADDR_EN to build the bad virtual address
// register. Without it badvaddr_o is tied to zero.
module except_ctrl #(
    parameter int unsigned N_HWINT    = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic [31:0]        pc_i,
    input  logic               in_ds_i,
    input  logic [7:0]         except_i,
    input  logic               adel_i,
    input  logic               ades_i,
    input  logic [31:0]        addr_i,
    input  logic [N_HWINT-1:0] hw_int_i,
    input  logic [31:0]        cp0_status_i,
    input  logic [31:0]        cp0_cause_i,
    input  logic [31:0]        cp0_epc_i,
    input  logic               cp0_ack_i,
    output logic               exc_valid_o,
    output logic [31:0]        excepttype_o,
    output logic [31:0]        epc_o,
    output logic               bd_o,
    output logic [31:0]        badvaddr_o,
    output logic               flush_o,
    output logic [31:0]        newpc_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReport,
        StFlush
    } state_e;

    localparam logic [3:0] CodeInt  = 4'h1;
    localparam logic [3:0] CodeAdel = 4'h4;
    localparam logic [3:0] CodeAdes = 4'h5;
    localparam logic [3:0] CodeSys  = 4'h8;
    localparam logic [3:0] CodeBp   = 4'h9;
    localparam logic [3:0] CodeRi   = 4'hA;
    localparam logic [3:0] CodeOv   = 4'hC;
    localparam logic [3:0] CodeEret = 4'hE;

    state_e state_q, state_d;

    logic [N_HWINT-1:0] sync1_q, sync2_q;

    logic        exc_valid_q, exc_valid_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic        flush_q, flush_d;
    logic [31:0] newpc_q, newpc_d;
    logic        busy_q, busy_d;

    logic [5:0]  hw_int6;
    logic [7:0]  int_pend;
    logic        int_req;
    logic        cause_hit;
    logic        is_eret;
    logic [3:0]  sel_code;
    logic        capture;

    // Collects CP0/flag bits this block never looks at.
    logic unused_bits;
    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                           cp0_cause_i[31:16], cp0_cause_i[7:0], except_i[1:0]};

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= hw_int_i;
            sync2_q <= sync1_q;
        end
    end

    // Interrupt request: pending lines masked by IM, gated by IE=1 and EXL=0.
    always_comb begin
        hw_int6 = '0;
        for (int i = 0; i < int'(N_HWINT); i++) begin
            hw_int6[i] = sync2_q[i];
        end
        int_pend = {cp0_cause_i[15:10] | hw_int6, cp0_cause_i[9:8]} & cp0_status_i[15:8];
        int_req  = (int_pend != 8'h00) && !cp0_status_i[1] && cp0_status_i[0];
    end

    // Priority encoder over all exception causes.
    always_comb begin
        cause_hit = 1'b1;
        is_eret   = 1'b0;
        sel_code  = 4'h0;
        if (int_req) begin
            sel_code = CodeInt;
        end else if (except_i[7] || adel_i) begin
            sel_code = CodeAdel;
        end else if (ades_i) begin
            sel_code = CodeAdes;
        end else if (except_i[6]) begin
            sel_code = CodeSys;
        end else if (except_i[5]) begin
            sel_code = CodeBp;
        end else if (except_i[4]) begin
            sel_code = CodeEret;
            is_eret  = 1'b1;
        end else if (except_i[3]) begin
            sel_code = CodeRi;
        end else if (except_i[2]) begin
            sel_code = CodeOv;
        end else begin
            cause_hit = 1'b0;
        end
    end

    assign capture = (state_q == StIdle) && valid_i && !stall_i && cause_hit;

    // Next-state and registered-output logic for the report/flush sequence.
    always_comb begin
        state_d      = state_q;
        exc_valid_d  = exc_valid_q;
        excepttype_d = excepttype_q;
        epc_d        = epc_q;
        bd_d         = bd_q;
        flush_d      = flush_q;
        newpc_d      = newpc_q;
        busy_d       = busy_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    excepttype_d = {28'h0000000, sel_code};
                    epc_d        = in_ds_i ? (pc_i - 32'd4) : pc_i;
                    bd_d         = in_ds_i;
                    busy_d       = 1'b1;
                    if (is_eret) begin
                        // eret needs no CP0 handshake: jump back immediately.
                        state_d = StFlush;
                        flush_d = 1'b1;
                        newpc_d = cp0_epc_i;
                    end else begin
                        state_d     = StReport;
                        exc_valid_d = 1'b1;
                    end
                end
            end
            StReport: begin
                if (cp0_ack_i) begin
                    state_d     = StFlush;
                    exc_valid_d = 1'b0;
                    flush_d     = 1'b1;
                    newpc_d     = EXC_VECTOR;
                end
            end
            StFlush: begin
                state_d = StIdle;
                flush_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = StIdle;
                exc_valid_d = 1'b0;
                flush_d     = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            exc_valid_q  <= 1'b0;
            excepttype_q <= '0;
            epc_q        <= '0;
            bd_q         <= 1'b0;
            flush_q      <= 1'b0;
            newpc_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exc_valid_q  <= exc_valid_d;
            excepttype_q <= excepttype_d;
            epc_q        <= epc_d;
            bd_q         <= bd_d;
            flush_q      <= flush_d;
            newpc_q      <= newpc_d;
            busy_q       <= busy_d;
        end
    end

`ifdef EXC_BADVADDR_EN
    logic [31:0] sel_bad;
    logic [31:0] badvaddr_q, badvaddr_d;

    // Faulting address: fetch errors report the PC, data errors the access address.
    always_comb begin
        sel_bad = '0;
        if (!int_req) begin
            if (except_i[7]) begin
                sel_bad = pc_i;
            end else if (adel_i || ades_i) begin
                sel_bad = addr_i;
            end
        end
        badvaddr_d = badvaddr_q;
        if (capture) begin
            badvaddr_d = sel_bad;
        end
    end

    // Bad address register, loaded together with the rest of the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
        end
    end

    assign badvaddr_o = badvaddr_q;
`else
    logic unused_addr;
    assign unused_addr = ^addr_i;
    assign badvaddr_o  = '0;
`endif

    assign exc_valid_o  = exc_valid_q;
    assign excepttype_o = excepttype_q;
    assign epc_o        = epc_q;
    assign bd_o         = bd_q;
    assign flush_o      = flush_q;
    assign newpc_o      = newpc_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed testbench for except_ctrl with hand-computed expectations.
module tb_except_ctrl;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        in_ds_i;
    logic [7:0]  except_i;
    logic        adel_i;
    logic        ades_i;
    logic [31:0] addr_i;
    logic [5:0]  hw_int_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        cp0_ack_i;
    logic        exc_valid_o;
    logic [31:0] excepttype_o;
    logic [31:0] epc_o;
    logic        bd_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        busy_o;

    int n_cmp;
    int n_fail;

    except_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .stall_i      (stall_i),
        .pc_i         (pc_i),
        .in_ds_i      (in_ds_i),
        .except_i     (except_i),
        .adel_i       (adel_i),
        .ades_i       (ades_i),
        .addr_i       (addr_i),
        .hw_int_i     (hw_int_i),
        .cp0_status_i (cp0_status_i),
        .cp0_cause_i  (cp0_cause_i),
        .cp0_epc_i    (cp0_epc_i),
        .cp0_ack_i    (cp0_ack_i),
        .exc_valid_o  (exc_valid_o),
        .excepttype_o (excepttype_o),
        .epc_o        (epc_o),
        .bd_o         (bd_o),
        .badvaddr_o   (badvaddr_o),
        .flush_o      (flush_o),
        .newpc_o      (newpc_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_i  = 1'b0;
        stall_i  = 1'b0;
        in_ds_i  = 1'b0;
        except_i = 8'h00;
        adel_i   = 1'b0;
        ades_i   = 1'b0;
        addr_i   = 32'h0;
    endtask

    // Acknowledge the pending report, check the flush cycle, return to idle.
    task automatic ack_and_drain(input string tag);
        cp0_ack_i = 1'b1;
        tick();
        cp0_ack_i = 1'b0;
        check({tag, "_flush"}, {31'b0, flush_o}, 32'h1);
        check({tag, "_newpc"}, newpc_o, 32'hBFC00380);
        check({tag, "_valid_drop"}, {31'b0, exc_valid_o}, 32'h0);
        tick();
        check({tag, "_flush_end"}, {31'b0, flush_o}, 32'h0);
        check({tag, "_idle"}, {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst          = 1'b1;
        pc_i         = 32'h0;
        hw_int_i     = 6'h00;
        cp0_status_i = 32'h0;
        cp0_cause_i  = 32'h0;
        cp0_epc_i    = 32'h0;
        cp0_ack_i    = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("rst_valid", {31'b0, exc_valid_o}, 32'h0);
        check("rst_flush", {31'b0, flush_o}, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_type", excepttype_o, 32'h0);
        check("rst_newpc", newpc_o, 32'h0);
        rst = 1'b0;
        tick();

        // Syscall, not in delay slot.
        valid_i  = 1'b1;
        pc_i     = 32'h80001000;
        except_i = 8'h40;
        tick();
        clear_inputs();
        check("sys_valid", {31'b0, exc_valid_o}, 32'h1);
        check("sys_type", excepttype_o, 32'h8);
        check("sys_epc", epc_o, 32'h80001000);
        check("sys_bd", {31'b0, bd_o}, 32'h0);
        check("sys_busy", {31'b0, busy_o}, 32'h1);
        check("sys_noflush", {31'b0, flush_o}, 32'h0);
        tick();
        check("sys_hold_valid", {31'b0, exc_valid_o}, 32'h1);
        check("sys_hold_epc", epc_o, 32'h80001000);
        ack_and_drain("sys");

        // Acknowledge while idle must do nothing.
        cp0_ack_i = 1'b1;
        tick();
        cp0_ack_i = 1'b0;
        check("ack_idle_valid", {31'b0, exc_valid_o}, 32'h0);
        check("ack_idle_flush", {31'b0, flush_o}, 32'h0);

        // Overflow in a delay slot; a syscall while busy is ignored.
        valid_i  = 1'b1;
        pc_i     = 32'h80002004;
        in_ds_i  = 1'b1;
        except_i = 8'h04;
        tick();
        check("ov_type", excepttype_o, 32'hC);
        check("ov_epc", epc_o, 32'h80002000);
        check("ov_bd", {31'b0, bd_o}, 32'h1);
        pc_i     = 32'h80009000;
        in_ds_i  = 1'b0;
        except_i = 8'h40;
        tick();
        clear_inputs();
        check("busy_ignore_type", excepttype_o, 32'hC);
        check("busy_ignore_epc", epc_o, 32'h80002000);
        ack_and_drain("ov");

        // Stalled cause waits for the first unstalled cycle.
        valid_i  = 1'b1;
        stall_i  = 1'b1;
        pc_i     = 32'h80004000;
        except_i = 8'h40;
        tick();
        check("stall_nocap", {31'b0, exc_valid_o}, 32'h0);
        stall_i = 1'b0;
        tick();
        clear_inputs();
        check("unstall_valid", {31'b0, exc_valid_o}, 32'h1);
        check("unstall_epc", epc_o, 32'h80004000);
        ack_and_drain("stall");

        // Data AdEL beats syscall.
        valid_i  = 1'b1;
        pc_i     = 32'h80005000;
        except_i = 8'h40;
        adel_i   = 1'b1;
        addr_i   = 32'h00000003;
        tick();
        clear_inputs();
        check("adel_type", excepttype_o, 32'h4);
`ifdef EXC_BADVADDR_EN
        check("adel_badvaddr", badvaddr_o, 32'h00000003);
`else
        check("adel_badvaddr", badvaddr_o, 32'h00000000);
`endif
        ack_and_drain("adel");

        // AdES beats break.
        valid_i  = 1'b1;
        pc_i     = 32'h80005100;
        except_i = 8'h20;
        ades_i   = 1'b1;
        addr_i   = 32'h00001002;
        tick();
        clear_inputs();
        check("ades_type", excepttype_o, 32'h5);
`ifdef EXC_BADVADDR_EN
        check("ades_badvaddr", badvaddr_o, 32'h00001002);
`else
        check("ades_badvaddr", badvaddr_o, 32'h00000000);
`endif
        ack_and_drain("ades");

        // Break beats reserved instruction.
        valid_i  = 1'b1;
        pc_i     = 32'h80005200;
        except_i = 8'h28;
        tick();
        clear_inputs();
        check("bp_type", excepttype_o, 32'h9);
        ack_and_drain("bp");

        // eret flushes straight to EPC, never reports.
        cp0_epc_i = 32'h80003000;
        valid_i   = 1'b1;
        pc_i      = 32'h80005300;
        except_i  = 8'h10;
        tick();
        clear_inputs();
        cp0_epc_i = 32'h0;
        check("eret_flush", {31'b0, flush_o}, 32'h1);
        check("eret_newpc", newpc_o, 32'h80003000);
        check("eret_novalid", {31'b0, exc_valid_o}, 32'h0);
        check("eret_busy", {31'b0, busy_o}, 32'h1);
        tick();
        check("eret_flush_end", {31'b0, flush_o}, 32'h0);
        check("eret_novalid2", {31'b0, exc_valid_o}, 32'h0);
        check("eret_idle", {31'b0, busy_o}, 32'h0);

        // Hardware interrupt: captured on the third edge after assertion.
        cp0_status_i = 32'h00000401;
        valid_i      = 1'b1;
        pc_i         = 32'h80007000;
        hw_int_i     = 6'h01;
        tick();
        check("int_sync1", {31'b0, exc_valid_o}, 32'h0);
        tick();
        check("int_sync2", {31'b0, exc_valid_o}, 32'h0);
        tick();
        hw_int_i = 6'h00;
        clear_inputs();
        check("int_valid", {31'b0, exc_valid_o}, 32'h1);
        check("int_type", excepttype_o, 32'h1);
        check("int_epc", epc_o, 32'h80007000);
        ack_and_drain("int");

        // EXL set masks the interrupt.
        cp0_status_i = 32'h00000403;
        valid_i      = 1'b1;
        hw_int_i     = 6'h01;
        tick();
        tick();
        tick();
        tick();
        check("int_exl_nocap", {31'b0, exc_valid_o}, 32'h0);
        check("int_exl_busy", {31'b0, busy_o}, 32'h0);
        hw_int_i = 6'h00;
        clear_inputs();
        tick();
        tick();
        cp0_status_i = 32'h0;

        // Reset in the middle of REPORT.
        valid_i  = 1'b1;
        pc_i     = 32'h80008000;
        except_i = 8'h40;
        tick();
        clear_inputs();
        check("pre_rst_valid", {31'b0, exc_valid_o}, 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'b0, exc_valid_o}, 32'h0);
        check("mid_rst_busy", {31'b0, busy_o}, 32'h0);
        check("mid_rst_epc", epc_o, 32'h0);
        check("mid_rst_type", excepttype_o, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_exit_noflush", {31'b0, flush_o}, 32'h0);
        check("rst_exit_valid", {31'b0, exc_valid_o}, 32'h0);
        valid_i  = 1'b1;
        pc_i     = 32'h80006000;
        except_i = 8'h40;
        tick();
        clear_inputs();
        check("post_rst_valid", {31'b0, exc_valid_o}, 32'h1);
        check("post_rst_epc", epc_o, 32'h80006000);
        check("post_rst_type", excepttype_o, 32'h8);
        ack_and_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
